// File: rtl/recibir_adc.sv
`timescale 1ns/1ps
// recibir_adc: serial receiver for a 12-bit SPI-style ADC.
// Drives the ADC chip select, shifts in one FRAME_BITS-wide frame (MSB first) per
// conversion request and presents the raw frame plus the data LSBs with a
// one-cycle completion strobe.
// Build option: define RECIBIR_ADC_CONTINUOUS_EN to start on inicio level
// (back-to-back frames while held high); otherwise only a rising edge of inicio starts a frame.
module recibir_adc #(
  parameter int unsigned FRAME_BITS   = 16,
  parameter int unsigned DATA_BITS    = 12,
  parameter int unsigned QUIET_CYCLES = 1
) (
  input  logic                  clock44kHz,
  input  logic                  reset,
  input  logic                  datoADC,
  input  logic                  inicio,
  output logic [DATA_BITS-1:0]  Dato_sin_basura,
  output logic [FRAME_BITS-1:0] dout,
  output logic                  CS_out,
  output logic                  listo
);

  localparam int unsigned CNT_W      = $clog2(FRAME_BITS);
  localparam int unsigned QCNT_W     = $clog2(QUIET_CYCLES + 1);
  // DONE already provides one high cycle, so QUIET only covers the remainder
  localparam int unsigned QUIET_LAST = (QUIET_CYCLES > 1) ? QUIET_CYCLES - 2 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    QUIET = 2'd3
  } state_t;

  state_t                state, state_nx;
  logic [FRAME_BITS-2:0] sr, sr_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [QCNT_W-1:0]     qcnt, qcnt_nx;
  logic                  cs_nx;
  logic                  listo_nx;
  logic [FRAME_BITS-1:0] dout_nx;
  logic [DATA_BITS-1:0]  dato_nx;
  logic [FRAME_BITS-1:0] frame_c;
  logic                  start_c;
  logic                  last_bit_c;
  logic                  quiet_end_c;

  // Frame as it would look with the current serial bit appended
  assign frame_c     = {sr, datoADC};
  assign last_bit_c  = (cnt == CNT_W'(FRAME_BITS - 1));
  assign quiet_end_c = (qcnt == QCNT_W'(QUIET_LAST));

`ifdef RECIBIR_ADC_CONTINUOUS_EN
  // Level-sensitive start: holding inicio high keeps conversions running
  assign start_c = inicio;
`else
  logic inicio_q;

  // inicio history for rising-edge detection
  always_ff @(posedge clock44kHz or negedge reset) begin
    if (!reset) inicio_q <= 1'b0;
    else        inicio_q <= inicio;
  end

  assign start_c = inicio & ~inicio_q;
`endif

  // State register
  always_ff @(posedge clock44kHz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start_c) state_nx = SHIFT;
      SHIFT: if (last_bit_c) state_nx = DONE;
      DONE:  state_nx = (QUIET_CYCLES > 1) ? QUIET : IDLE;
      QUIET: if (quiet_end_c) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output / datapath next values, registered below
  always_comb begin
    cs_nx    = 1'b1;
    listo_nx = 1'b0;
    sr_nx    = sr;
    cnt_nx   = cnt;
    qcnt_nx  = qcnt;
    dout_nx  = dout;
    dato_nx  = Dato_sin_basura;
    unique case (state)
      IDLE: begin
        cnt_nx = '0;
        if (start_c) cs_nx = 1'b0;
      end
      SHIFT: begin
        sr_nx  = frame_c[FRAME_BITS-2:0];
        cnt_nx = cnt + CNT_W'(1);
        if (last_bit_c) begin
          cnt_nx   = '0;
          dout_nx  = frame_c;
          dato_nx  = frame_c[DATA_BITS-1:0];
          listo_nx = 1'b1;
        end else begin
          cs_nx = 1'b0;
        end
      end
      DONE: begin
        qcnt_nx = '0;
      end
      QUIET: begin
        qcnt_nx = qcnt + QCNT_W'(1);
      end
      default: begin
        cnt_nx = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clock44kHz or negedge reset) begin
    if (!reset) begin
      CS_out          <= 1'b1;
      listo           <= 1'b0;
      sr              <= '0;
      cnt             <= '0;
      qcnt            <= '0;
      dout            <= '0;
      Dato_sin_basura <= '0;
    end else begin
      CS_out          <= cs_nx;
      listo           <= listo_nx;
      sr              <= sr_nx;
      cnt             <= cnt_nx;
      qcnt            <= qcnt_nx;
      dout            <= dout_nx;
      Dato_sin_basura <= dato_nx;
    end
  end

endmodule

// File: tb/tb_recibir_adc.sv
`timescale 1ns/1ps
// tb_recibir_adc: directed-vector bench for the ADC serial receiver.
module tb_recibir_adc;

  logic        clock44kHz;
  logic        reset;
  logic        datoADC;
  logic        inicio;
  logic [11:0] Dato_sin_basura;
  logic [15:0] dout;
  logic        CS_out;
  logic        listo;

  int total;
  int bad;

  recibir_adc dut (
    .clock44kHz      (clock44kHz),
    .reset           (reset),
    .datoADC         (datoADC),
    .inicio          (inicio),
    .Dato_sin_basura (Dato_sin_basura),
    .dout            (dout),
    .CS_out          (CS_out),
    .listo           (listo)
  );

  // 10 ns sample clock
  initial clock44kHz = 1'b0;
  always #5 clock44kHz = ~clock44kHz;

  // Single comparison point
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later
  task automatic step();
    @(posedge clock44kHz);
    #1;
  endtask

  // Full frame from an inicio rise; inicio dropped after edge drop_after (0 = keep until end)
  task automatic send_frame(input logic [15:0] bits, input int drop_after,
                            input logic [15:0] exp_dout, input logic [11:0] exp_dato,
                            input string tag);
    inicio = 1'b1;
    step();                              // E0
    check({tag, "_cs_e0"}, 32'(CS_out), 32'd0);
    for (int i = 15; i >= 0; i--) begin
      datoADC = bits[i];
      step();                            // E(16-i)
      if ((16 - i) == drop_after) inicio = 1'b0;
      if (i > 0) begin
        check({tag, "_cs_low"}, 32'(CS_out), 32'd0);
        check({tag, "_listo_lo"}, 32'(listo), 32'd0);
      end
    end
    check({tag, "_listo"}, 32'(listo), 32'd1);
    check({tag, "_cs_hi"}, 32'(CS_out), 32'd1);
    check({tag, "_dout"}, 32'(dout), 32'(exp_dout));
    check({tag, "_dato"}, 32'(Dato_sin_basura), 32'(exp_dato));
    step();                              // E17
    check({tag, "_listo_1cyc"}, 32'(listo), 32'd0);
    check({tag, "_cs_e17"}, 32'(CS_out), 32'd1);
    inicio = 1'b0;
    step();
  endtask

  initial begin
    int n_listo;
    int first_c;
    int last_c;
    logic prev_listo;
    logic [15:0] bits;

    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    datoADC = 1'b0;
    inicio  = 1'b0;

    // 1: reset holds outputs regardless of serial activity
    for (int c = 0; c < 4; c++) begin
      datoADC = ~datoADC;
      inicio  = ~inicio;
      step();
    end
    check("t1_cs", 32'(CS_out), 32'd1);
    check("t1_listo", 32'(listo), 32'd0);
    check("t1_dout", 32'(dout), 32'h0);
    check("t1_dato", 32'(Dato_sin_basura), 32'h0);
    inicio = 1'b0;
    reset  = 1'b1;
    step();
    step();
    check("t1_idle_cs", 32'(CS_out), 32'd1);

    // 2: basic frame
    send_frame(16'hF555, 0, 16'hF555, 12'h555, "t2");

    // 6: hold between frames, then second frame
    for (int c = 0; c < 5; c++) begin
      datoADC = ~datoADC;
      step();
      check("t6_hold_dout", 32'(dout), 32'hF555);
      check("t6_hold_dato", 32'(Dato_sin_basura), 32'h555);
      check("t6_hold_listo", 32'(listo), 32'd0);
    end
    send_frame(16'hAFFF, 0, 16'hAFFF, 12'hFFF, "t6");

    // 3: inicio dropped after E3 does not abort the frame
    send_frame(16'h0F0A, 3, 16'h0F0A, 12'hF0A, "t3");

    // 4: reset at E8 aborts the frame
    bits   = 16'h1234;
    inicio = 1'b1;
    step();                              // E0
    for (int i = 15; i >= 8; i--) begin
      datoADC = bits[i];
      step();                            // E1..E8
    end
    reset  = 1'b0;
    inicio = 1'b0;
    #1;
    check("t4_cs", 32'(CS_out), 32'd1);
    check("t4_listo", 32'(listo), 32'd0);
    check("t4_dout", 32'(dout), 32'h0);
    check("t4_dato", 32'(Dato_sin_basura), 32'h0);
    step();
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      check("t4_no_listo", 32'(listo), 32'd0);
    end
    check("t4_dout_kept", 32'(dout), 32'h0);
    send_frame(16'h3C96, 0, 16'h3C96, 12'hC96, "t4f");

    // 5: inicio held high for 60 cycles
    datoADC    = 1'b1;
    inicio     = 1'b1;
    n_listo    = 0;
    first_c    = 0;
    last_c     = 0;
    prev_listo = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (listo) begin
        n_listo++;
        check("t5_wide", 32'(prev_listo), 32'd0);
        if (n_listo == 1) first_c = c;
        else              check("t5_period", 32'(c - last_c), 32'd18);
        last_c = c;
      end
      prev_listo = listo;
    end
    check("t5_first", 32'(first_c), 32'd17);
`ifdef RECIBIR_ADC_CONTINUOUS_EN
    check("t5_count", 32'(n_listo), 32'd3);
`else
    check("t5_count", 32'(n_listo), 32'd1);
`endif
    inicio = 1'b0;
    for (int c = 0; c < 24; c++) step();
    check("t5_dout", 32'(dout), 32'hFFFF);
    check("t5_dato", 32'(Dato_sin_basura), 32'hFFF);
    check("t5_cs_idle", 32'(CS_out), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
